// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Each grant runs one op through the ALU and returns it on a response handshake.
module alu_arbiter #(
    parameter int ALU_LAT = 1,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [5:0]   req0_opsel,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [5:0]   req1_opsel,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp_data,
    output logic [5:0]   alu_opsel,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_out,
    output logic         busy,
    output logic [15:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(ALU_LAT);

    state_t     state;
    logic       ptr;
    logic       owner;
    logic [3:0] cnt;

    logic gnt_id;
    logic acc0;
    logic acc1;
    logic rsp_hs;

    // With both valid the pointer decides; otherwise the lone valid wins.
    always_comb begin
        gnt_id     = (req0_valid && req1_valid) ? ptr : req1_valid;
        req0_ready = (state == IDLE) && req0_valid && !gnt_id;
        req1_ready = (state == IDLE) && req1_valid && gnt_id;
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
        rsp_hs     = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
            alu_opsel  <= 6'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            op_count   <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc0 || acc1) begin
                        alu_opsel <= acc1 ? req1_opsel : req0_opsel;
                        alu_a     <= acc1 ? req1_a : req0_a;
                        alu_b     <= acc1 ? req1_b : req0_b;
                        owner     <= acc1;
                        ptr       <= ~acc1;
                        cnt       <= LAT;
                        busy      <= 1'b1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_data   <= alu_out;
                        rsp0_valid <= !owner;
                        rsp1_valid <= owner;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        op_count   <= op_count + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural one-cycle ALU.
// Expected results come from a scoreboard filled at accept time.
module tb_alu_arbiter;

    localparam int LAT = 1;
    localparam int W   = 32;

    logic         clk;
    logic         reset;
    logic         req0_valid, req0_ready;
    logic [5:0]   req0_opsel;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [5:0]   req1_opsel;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready;
    logic         rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp_data;
    logic [5:0]   alu_opsel;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         busy;
    logic [15:0]  op_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_cyc;

    typedef struct {
        int          id;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    alu_arbiter #(.ALU_LAT(LAT), .W(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opsel(req0_opsel), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opsel(req1_opsel), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data),
        .alu_opsel(alu_opsel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .busy(busy), .op_count(op_count)
    );

    function automatic logic [31:0] alu_f(logic [5:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            6'h00:   return a + b;
            6'h01:   return a - b;
            6'h04:   return a & b;
            6'h0F:   return {b[15:0], 16'h0000};
            6'h1F:   return ($signed(a) > 0) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        alu_out <= alu_f(alu_opsel, alu_a, alu_b);
        cyc     <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(int id, logic [5:0] op, logic [31:0] a, logic [31:0] b);
        if (id == 0) begin
            req0_valid = 1'b1; req0_opsel = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_opsel = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic issue(int id, logic [5:0] op, logic [31:0] a, logic [31:0] b, bit keep);
        int   n;
        exp_t e;
        drive(id, op, a, b);
        #1;
        n = 0;
        while (!(id == 0 ? req0_ready : req1_ready) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            chk("accept_timeout", 32'(id == 0 ? req0_ready : req1_ready), 32'd1);
        end else begin
            tick();
            acc_cyc = cyc;
            e.id = id;
            e.d  = alu_f(op, a, b);
            sb.push_back(e);
        end
        if (!keep) begin
            if (id == 0) req0_valid = 1'b0;
            else         req1_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(int id);
        int   n;
        exp_t e;
        n = 0;
        while (!(id == 0 ? rsp0_valid : rsp1_valid) && n < 40) begin
            tick();
            n++;
        end
        chk("rsp_valid", 32'(id == 0 ? rsp0_valid : rsp1_valid), 32'd1);
        chk("rsp_other", 32'(id == 0 ? rsp1_valid : rsp0_valid), 32'd0);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("rsp_owner", 32'(id), 32'(e.id));
            chk("rsp_data", rsp_data, e.d);
        end
    endtask

    task automatic reset_pulse();
        #3 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp0", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1", 32'(rsp1_valid), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_opsel", 32'(alu_opsel), 32'd0);
        chk("rst_a", alu_a, 32'd0);
        chk("rst_b", alu_b, 32'd0);
        chk("rst_cnt", 32'(op_count), 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("rst_busy_post", 32'(busy), 32'd0);
        sb.delete();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 0; req0_opsel = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_opsel = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        tick();
        tick();
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_cnt", 32'(op_count), 32'd0);
        chk("init_data", rsp_data, 32'd0);
        reset = 1'b0;
        tick();

        // single op: ADD 5+5
        rsp0_ready = 1'b1;
        drive(0, 6'h00, 32'd5, 32'd5);
        #1;
        chk("s_r0rdy", 32'(req0_ready), 32'd1);
        issue(0, 6'h00, 32'd5, 32'd5, 0);
        chk("s_busy", 32'(busy), 32'd1);
        for (int i = 0; i <= LAT; i++) begin
            chk("s_early", 32'(rsp0_valid), 32'd0);
            tick();
        end
        chk("s_rise", 32'(rsp0_valid), 32'd1);
        chk("s_data", rsp_data, 32'h0000000A);
        wait_rsp(0);
        tick();
        chk("s_opcnt", 32'(op_count), 32'd1);
        chk("s_idle", 32'(busy), 32'd0);

        // backpressure on requester 0 while requester 1 waits
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        issue(0, 6'h00, 32'd7, 32'd8, 0);
        drive(1, 6'h04, 32'hF0F0F0F0, 32'h0000FFFF);
        wait_rsp(0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(rsp0_valid), 32'd1);
            chk("bp_data", rsp_data, 32'd15);
            chk("bp_a", alu_a, 32'd7);
            chk("bp_b", alu_b, 32'd8);
            chk("bp_r1rdy", 32'(req1_ready), 32'd0);
        end
        rsp0_ready = 1'b1;
        tick();
        chk("bp_idle", 32'(busy), 32'd0);
        chk("bp_r1grant", 32'(req1_ready), 32'd1);
        issue(1, 6'h04, 32'hF0F0F0F0, 32'h0000FFFF, 0);
        chk("bp_acc_busy", 32'(busy), 32'd1);
        wait_rsp(1);
        tick();
        chk("bp_opcnt", 32'(op_count), 32'd3);

        // async reset while in RESP
        rsp0_ready = 1'b0;
        issue(0, 6'h00, 32'd1, 32'd2, 0);
        wait_rsp(0);
        reset_pulse();

        // contention straight after reset: req0 wins
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        drive(1, 6'h04, 32'hFFFFFFFF, 32'd5);
        drive(0, 6'h01, 32'd5, 32'hFFFFFFFF);
        #1;
        chk("c_r0rdy", 32'(req0_ready), 32'd1);
        chk("c_r1rdy0", 32'(req1_ready), 32'd0);
        issue(0, 6'h01, 32'd5, 32'hFFFFFFFF, 0);
        for (int i = 0; i <= LAT; i++) begin
            chk("c_r1busy", 32'(req1_ready), 32'd0);
            tick();
        end
        wait_rsp(0);
        chk("c_sub", rsp_data, 32'h00000006);
        chk("c_r1resp", 32'(req1_ready), 32'd0);
        tick();
        issue(1, 6'h04, 32'hFFFFFFFF, 32'd5, 0);
        wait_rsp(1);
        chk("c_and", rsp_data, 32'h00000005);
        tick();
        chk("c_opcnt", 32'(op_count), 32'd2);
        drive(0, 6'h00, 32'd0, 32'd0);
        drive(1, 6'h00, 32'd0, 32'd0);
        #1;
        chk("c_ptr0", 32'(req0_ready), 32'd1);
        chk("c_ptr1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // reset during EXEC aborts the op
        issue(0, 6'h00, 32'd3, 32'd4, 0);
        reset_pulse();
        for (int i = 0; i < 6; i++) begin
            chk("x_rsp0", 32'(rsp0_valid), 32'd0);
            chk("x_rsp1", 32'(rsp1_valid), 32'd0);
            tick();
        end
        chk("x_opcnt", 32'(op_count), 32'd0);
        issue(1, 6'h01, 32'd100, 32'd1, 0);
        wait_rsp(1);
        tick();
        chk("x_opcnt1", 32'(op_count), 32'd1);

        // lone requester 1: back-to-back at minimum interval
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            int prev;
            prev = acc_cyc;
            issue(1, 6'h0F, 32'(k), 32'(k + 1), 1);
            chk("f_busy_hi", 32'(busy), 32'd1);
            if (k > 0) chk("f_interval", 32'(acc_cyc - prev), 32'(LAT + 3));
            wait_rsp(1);
            tick();
            chk("f_opcnt", 32'(op_count), 32'(k + 1));
            chk("f_busy_lo", 32'(busy), 32'd0);
        end
        req1_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
